// File: rtl/instr_fetch.sv
// Fetch stage: drives the synchronous-read instruction BRAM and holds the IF/ID register.
// Optional performance counters are enabled with `define IFETCH_PERF_CNT_EN.
module instr_fetch #(
    parameter int unsigned          PC_WIDTH = 9,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_en,
    input  logic [31:0]         imem_rdata,
    input  logic                stall_in,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    input  logic                user_resume,
    output logic [31:0]         if_instr,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic                if_valid,
    output logic                user_stalled,
    output logic                la_trigger
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         bubble_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_USR_HALT
    } state_t;

    state_t                state, state_d;
    logic [PC_WIDTH-1:0]   fetch_pc, fetch_pc_d;
    logic [PC_WIDTH-1:0]   f2_pc, f2_pc_d;
    logic                  f2_valid, f2_valid_d;
    logic                  redir_q;
    logic [31:0]           if_instr_d;
    logic [PC_WIDTH-1:0]   if_pc_d;
    logic                  if_valid_d;
    logic                  la_d;
    logic                  capture;
    logic                  halt_hit;

    assign imem_addr = fetch_pc;

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            fetch_pc     <= RESET_PC;
            f2_pc        <= '0;
            f2_valid     <= 1'b0;
            redir_q      <= 1'b0;
            if_instr     <= '0;
            if_pc        <= '0;
            if_valid     <= 1'b0;
            la_trigger   <= 1'b0;
            user_stalled <= 1'b0;
        end else begin
            state        <= state_d;
            fetch_pc     <= fetch_pc_d;
            f2_pc        <= f2_pc_d;
            f2_valid     <= f2_valid_d;
            redir_q      <= redirect_valid;
            if_instr     <= if_instr_d;
            if_pc        <= if_pc_d;
            if_valid     <= if_valid_d;
            la_trigger   <= la_d;
            user_stalled <= (state_d == S_USR_HALT);
        end
    end

    // Next-state, BRAM enable and IF/ID load logic
    always_comb begin
        state_d    = state;
        fetch_pc_d = fetch_pc;
        f2_pc_d    = f2_pc;
        f2_valid_d = f2_valid;
        if_instr_d = if_instr;
        if_pc_d    = if_pc;
        if_valid_d = if_valid;
        la_d       = 1'b0;

        // The read for a redirect target is issued even under a hazard stall
        imem_en  = (state == S_FETCH) && (!stall_in || redir_q);
        capture  = !redirect_valid && !stall_in;
        halt_hit = capture && f2_valid && imem_rdata[30];

        unique case (state)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (!run)          state_d = S_IDLE;
                else if (halt_hit) state_d = S_USR_HALT;
            end
            S_USR_HALT: begin
                if (user_resume) state_d = run ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (imem_en) begin
            f2_pc_d    = fetch_pc;
            f2_valid_d = 1'b1;
            fetch_pc_d = fetch_pc + PC_WIDTH'(1);
        end

        if (capture) begin
            if (f2_valid) begin
                if_instr_d = imem_rdata;
                if_pc_d    = f2_pc;
                if_valid_d = 1'b1;
                la_d       = imem_rdata[31];
            end else begin
                if_instr_d = '0;
                if_valid_d = 1'b0;
            end
        end

        // Leaving FETCH or halting drops the younger read and rewinds behind the last captured one
        if (state == S_FETCH && !run) begin
            f2_valid_d = 1'b0;
            fetch_pc_d = f2_valid ? (f2_pc + PC_WIDTH'(1)) : fetch_pc;
        end else if (halt_hit) begin
            f2_valid_d = 1'b0;
            fetch_pc_d = f2_pc + PC_WIDTH'(1);
        end

        if (redirect_valid) begin
            state_d    = run ? S_FETCH : S_IDLE;
            fetch_pc_d = redirect_target;
            f2_valid_d = 1'b0;
            if_instr_d = '0;
            if_valid_d = 1'b0;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Capture counters; both hold while stalled or redirected
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (capture && f2_valid)
                fetch_count <= fetch_count + 32'd1;
            if (capture && !f2_valid && state != S_IDLE)
                bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder in the 5-bit-opcode pipelined core.
- Drives the synchronous-read instruction BRAM and tracks the in-flight read.
- Holds the IF/ID pipeline register (instruction, PC, valid) whose instruction output feeds the decoder.
- Handles hazard stalls, branch/jump redirects, the user-stall bit (instr[30]) and the LA-trigger bit (instr[31]).

Parameters:
- PC_WIDTH, 9, instruction-address width; IMEM depth is 2^PC_WIDTH words.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  level; fetch is permitted while high.
- imem_addr  out  PC_WIDTH  BRAM address; equals fetch_pc.
- imem_en  out  1  BRAM read enable; BRAM output holds its value while low.
- imem_rdata  in  32  BRAM data; mem[addr] appears 1 cycle after an enabled edge.
- stall_in  in  1  hazard stall from downstream; IF/ID holds.
- redirect_valid  in  1  single-cycle pulse from EX on a taken branch or jump.
- redirect_target  in  PC_WIDTH  new fetch address.
- user_resume  in  1  single-cycle pulse; releases a user stall.
- if_instr  out  32  IF/ID instruction; 0 (noop) when not valid.
- if_pc  out  PC_WIDTH  PC of if_instr.
- if_valid  out  1  if_instr is a real instruction.
- user_stalled  out  1  high while in USR_HALT.
- la_trigger  out  1  1-cycle pulse when an instruction with bit31=1 is captured into IF/ID.

Behaviour:
- Internal state:
  - fetch_pc
  - f2_valid and f2_pc: the read in flight, whose data is on imem_rdata.
  - FSM with states IDLE, FETCH, USR_HALT.
- Reset values:
  - fetch_pc=RESET_PC, f2_valid=0, f2_pc=0.
  - if_instr=0, if_pc=0, if_valid=0.
  - la_trigger=0, user_stalled=0, state=IDLE.
- Reset has priority over every other input, including in mid-operation. Any in-flight read is discarded.
- imem_en = (state==FETCH) && !stall_in. It is also 1 on the cycle after a redirect, unless in IDLE.
- FSM transitions:
  - IDLE -> FETCH when run=1. FETCH -> IDLE when run=0.
  - On FETCH -> IDLE, f2_valid is cleared and fetch_pc rewinds to f2_pc+1 if f2_valid, otherwise it is unchanged.
- Issue: in FETCH with imem_en=1, the edge sets f2_pc<=fetch_pc, f2_valid<=1 and fetch_pc<=fetch_pc+1. The increment is modulo 2^PC_WIDTH, so address 511 wraps to 0.
- Capture: when !stall_in, the IF/ID register loads as follows.
  - If f2_valid: if_instr<=imem_rdata, if_pc<=f2_pc, if_valid<=1.
  - If not f2_valid: if_instr<=0, if_valid<=0 (bubble).
- Stall: when stall_in=1, IF/ID, fetch_pc and f2 all hold. The BRAM is not enabled, so imem_rdata stays stable and no instruction is lost.
- Redirect: redirect_valid has priority over stall_in and user stall.
  - Edge actions: fetch_pc<=redirect_target, f2_valid<=0, if_valid<=0, if_instr<=0.
  - A pending USR_HALT is cancelled and the FSM goes to FETCH, unless run=0.
  - The target instruction appears on if_instr 2 cycles after the redirect edge, giving exactly 2 bubbles.
- User stall: when a captured imem_rdata has bit30=1, the instruction is still captured and the FSM enters USR_HALT.
  - On the same edge, f2_valid<=0 and fetch_pc<=f2_pc+1; the younger in-flight read is dropped.
  - Later captures insert bubbles; if_valid=0 after the halting instruction leaves.
  - user_resume, or a redirect, moves the FSM to FETCH.
  - user_resume asserted in the same cycle as the halt-causing capture is ignored.
- la_trigger is a registered pulse: 1 for exactly one cycle per capture with bit31=1. It stays 0 during stalled hold cycles.
- Throughput: 1 instruction per cycle in FETCH with no stalls. First instruction after run rises is valid 2 cycles after the IDLE->FETCH edge.

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- When defined, two 32-bit output ports are added:
  - fetch_count: increments on every valid capture.
  - bubble_count: increments on every capture of a bubble while state!=IDLE.
  - Both reset to 0, wrap at 2^32 and hold during stall_in.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, run=1, IMEM[0..3]=0x03,0x04,0x05,0x06 -> if_instr shows 0x03..0x06 on consecutive cycles with if_pc 0..3 and if_valid=1, starting 2 cycles after the run edge.
- stall_in high for 3 cycles while if_pc=2 -> if_instr/if_pc frozen at IMEM[2]/2 and imem_en=0. Resumes at if_pc=3 with no skipped or duplicated PC.
- redirect_valid with target=0x40 while if_pc=5 -> 2 bubbles (if_valid=0, if_instr=0), then if_pc=0x40; stall_in asserted simultaneously does not block it.
- IMEM[4]=0x40000003 (bit30 set) -> captured with if_pc=4, user_stalled=1 and only bubbles follow. user_resume -> next valid if_pc=5.
- IMEM[7]=0x80000004 -> la_trigger high exactly 1 cycle, coincident with if_pc=7; with stall_in held 2 cycles on that instruction, still 1 pulse.
- fetch_pc=511 with PC_WIDTH=9 -> next if_pc=0. Reset asserted mid-stream -> all outputs 0 next cycle and fetch restarts at RESET_PC.
